// File: rtl/conv_lbx_seq.sv
// Write-side sequencer and row-ordering stage for the 4-line buffer array.
// Assigns lines round-robin to buffers and rebuilds a 5-row column, oldest row first.

package conv_pkg;
    parameter int unsigned PIXEL_W     = 8;
    parameter int unsigned IMAGE_MAX_W = 8;
    typedef logic [PIXEL_W-1:0] pixel_t;
endpackage

module conv_lbx_seq
    import conv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           s_vld_i,
    output logic           s_rdy_o,
    input  pixel_t         s_dat_i,
    input  logic           s_sof_i,
    input  logic           s_eol_i,
    output logic [4:1]     lb_push_o,
    output logic           lb_pop_o,
    output pixel_t         lb_dat_o,
    output logic           lb_sof_o,
    output logic [4:1]     lb_eol_o,
    input  pixel_t [4:1]   lb_colD_i,
    output logic           m_vld_o,
    output pixel_t [5:1]   m_col_o,
    output logic [4:1]     m_row_vld_o,
    output logic           m_sof_o,
    output logic           m_eol_o,
    output logic           err_o
);

    localparam int unsigned PcntW = $clog2(IMAGE_MAX_W) + 1;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StActive = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [2:0]       lines_q, lines_d;
    logic [PcntW-1:0] pcnt_q, pcnt_d;
    logic             err_q, err_d;

    logic             acc;
    logic             sof_acc;
    logic             in_frame;
    logic             ovf;
    logic             proc;
    logic             drop_ovf;
    logic [1:0]       eff_ptr;
    logic [2:0]       eff_lines;
    logic [PcntW-1:0] eff_pcnt;

    // Pipe stages 1 and 2; the output registers form the third stage.
    logic       s1_vld_q, s1_sof_q, s1_eol_q;
    pixel_t     s1_pix_q;
    logic [1:0] s1_ptr_q;
    logic [2:0] s1_lines_q;
    logic       s2_vld_q, s2_sof_q, s2_eol_q;
    pixel_t     s2_pix_q;
    logic [1:0] s2_ptr_q;
    logic [2:0] s2_lines_q;

    logic         m_vld_q, m_vld_d;
    pixel_t [5:1] m_col_q, m_col_d;
    logic [4:1]   m_row_vld_q, m_row_vld_d;
    logic         m_sof_q, m_sof_d;
    logic         m_eol_q, m_eol_d;

    pixel_t [4:1] rot_col;
    logic [4:1]   rot_vld;

    function automatic pixel_t pick_col(input pixel_t [4:1] cols, input logic [1:0] idx);
        pixel_t sel;
        unique case (idx)
            2'd0:    sel = cols[1];
            2'd1:    sel = cols[2];
            2'd2:    sel = cols[3];
            default: sel = cols[4];
        endcase
        return sel;
    endfunction

    assign s_rdy_o  = !rst;
    assign acc      = s_vld_i & s_rdy_o;
    assign sof_acc  = acc & s_sof_i;
    assign in_frame = s_sof_i | (state_q == StActive);

    // A sof pixel sees a fresh frame: pointer, line count and column all zero.
    assign eff_ptr   = s_sof_i ? 2'd0 : wr_ptr_q;
    assign eff_lines = s_sof_i ? 3'd0 : lines_q;
    assign eff_pcnt  = s_sof_i ? '0   : pcnt_q;

    assign ovf      = (eff_pcnt == PcntW'(IMAGE_MAX_W)) & ~s_eol_i;
    assign proc     = acc & in_frame & ~ovf;
    assign drop_ovf = acc & in_frame & ovf;

    always_comb begin
        lb_push_o = '0;
        if (proc) begin
            unique case (eff_ptr)
                2'd0:    lb_push_o = 4'b0001;
                2'd1:    lb_push_o = 4'b0010;
                2'd2:    lb_push_o = 4'b0100;
                default: lb_push_o = 4'b1000;
            endcase
        end
    end

    assign lb_pop_o = proc & (eff_lines != 3'd0);
    assign lb_dat_o = proc ? s_dat_i : '0;
    assign lb_sof_o = proc & s_sof_i;
    assign lb_eol_o = lb_push_o & {4{s_eol_i}};

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        lines_d  = lines_q;
        pcnt_d   = pcnt_q;
        err_d    = err_q | drop_ovf;
        if (sof_acc) begin
            state_d = StActive;
        end
        if (proc) begin
            wr_ptr_d = eff_ptr;
            lines_d  = eff_lines;
            pcnt_d   = eff_pcnt + PcntW'(1);
            if (s_eol_i) begin
                wr_ptr_d = eff_ptr + 2'd1;
                lines_d  = (eff_lines == 3'd4) ? 3'd4 : eff_lines + 3'd1;
                pcnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            lines_q  <= '0;
            pcnt_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            lines_q  <= lines_d;
            pcnt_q   <= pcnt_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            s1_pix_q   <= '0;
            s1_ptr_q   <= '0;
            s1_lines_q <= '0;
            s2_vld_q   <= 1'b0;
            s2_sof_q   <= 1'b0;
            s2_eol_q   <= 1'b0;
            s2_pix_q   <= '0;
            s2_ptr_q   <= '0;
            s2_lines_q <= '0;
        end else begin
            s1_vld_q   <= proc;
            s1_sof_q   <= s_sof_i;
            s1_eol_q   <= s_eol_i;
            s1_pix_q   <= s_dat_i;
            s1_ptr_q   <= eff_ptr;
            s1_lines_q <= eff_lines;
            s2_vld_q   <= s1_vld_q;
            s2_sof_q   <= s1_sof_q;
            s2_eol_q   <= s1_eol_q;
            s2_pix_q   <= s1_pix_q;
            s2_ptr_q   <= s1_ptr_q;
            s2_lines_q <= s1_lines_q;
        end
    end

    // Row j reads the buffer j-1 slots past the write pointer; that is line n-5+j.
    for (genvar j = 1; j <= 4; j++) begin : g_rot
        assign rot_vld[j] = (s2_lines_q >= 3'(5 - j));
        assign rot_col[j] = rot_vld[j] ? pick_col(lb_colD_i, s2_ptr_q + 2'(j - 1)) : '0;
    end

    always_comb begin
        m_vld_d     = s2_vld_q;
        m_sof_d     = s2_vld_q & s2_sof_q;
        m_eol_d     = s2_vld_q & s2_eol_q;
        m_col_d     = m_col_q;
        m_row_vld_d = m_row_vld_q;
        if (s2_vld_q) begin
            m_col_d     = {s2_pix_q, rot_col};
            m_row_vld_d = rot_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_vld_q     <= 1'b0;
            m_col_q     <= '0;
            m_row_vld_q <= '0;
            m_sof_q     <= 1'b0;
            m_eol_q     <= 1'b0;
        end else begin
            m_vld_q     <= m_vld_d;
            m_col_q     <= m_col_d;
            m_row_vld_q <= m_row_vld_d;
            m_sof_q     <= m_sof_d;
            m_eol_q     <= m_eol_d;
        end
    end

    assign m_vld_o     = m_vld_q;
    assign m_col_o     = m_col_q;
    assign m_row_vld_o = m_row_vld_q;
    assign m_sof_o     = m_sof_q;
    assign m_eol_o     = m_eol_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_conv_lbx_seq.sv
// Randomized bench for conv_lbx_seq: emulates the four line buffers and checks
// every output column against a frame-history model of which past lines belong in each row.

module tb_conv_lbx_seq;
    import conv_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_vld_i;
    logic         s_rdy_o;
    pixel_t       s_dat_i;
    logic         s_sof_i;
    logic         s_eol_i;
    logic [4:1]   lb_push_o;
    logic         lb_pop_o;
    pixel_t       lb_dat_o;
    logic         lb_sof_o;
    logic [4:1]   lb_eol_o;
    pixel_t [4:1] lb_col_in;
    logic         m_vld_o;
    pixel_t [5:1] m_col_o;
    logic [4:1]   m_row_vld_o;
    logic         m_sof_o;
    logic         m_eol_o;
    logic         err_o;

    conv_lbx_seq dut (
        .clk         (clk),
        .rst         (rst),
        .s_vld_i     (s_vld_i),
        .s_rdy_o     (s_rdy_o),
        .s_dat_i     (s_dat_i),
        .s_sof_i     (s_sof_i),
        .s_eol_i     (s_eol_i),
        .lb_push_o   (lb_push_o),
        .lb_pop_o    (lb_pop_o),
        .lb_dat_o    (lb_dat_o),
        .lb_sof_o    (lb_sof_o),
        .lb_eol_o    (lb_eol_o),
        .lb_colD_i   (lb_col_in),
        .m_vld_o     (m_vld_o),
        .m_col_o     (m_col_o),
        .m_row_vld_o (m_row_vld_o),
        .m_sof_o     (m_sof_o),
        .m_eol_o     (m_eol_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Line-buffer emulator: read all four at the write column, data returns two cycles later.
    pixel_t mem [4][16];
    pixel_t rd1 [4];
    pixel_t rd2 [4];
    int     ecol = 0;
    int     eidx;
    assign eidx = lb_sof_o ? 0 : ecol;
    assign lb_col_in = {rd2[3], rd2[2], rd2[1], rd2[0]};

    initial begin
        for (int b = 0; b < 4; b++) begin
            rd1[b] = '0;
            rd2[b] = '0;
            for (int c = 0; c < 16; c++) mem[b][c] = '0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            ecol <= 0;
        end else if (lb_push_o != 4'b0000) begin
            for (int b = 0; b < 4; b++) rd1[b] <= mem[b][eidx];
            mem[$clog2(lb_push_o)][eidx] <= lb_dat_o;
            ecol <= (lb_eol_o != 4'b0000) ? 0 : eidx + 1;
        end
        for (int b = 0; b < 4; b++) rd2[b] <= rd1[b];
    end

    // Reference model: frame history indexed by line-within-frame and column.
    typedef struct {
        int unsigned            at;
        logic [5*PIXEL_W-1:0]   col;
        logic [3:0]             rv;
        logic                   sof;
        logic                   eol;
    } beat_t;

    beat_t  exp_q[$];
    pixel_t hist [32][16];
    bit     m_active = 0;
    int     m_line = 0;
    int     m_col = 0;
    bit     m_err = 0;

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            check_val("beat_missing", 64'(cyc), 64'(exp_q[0].at));
            void'(exp_q.pop_front());
        end
        if (m_vld_o) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_vld", 64'(m_vld_o), 64'(0));
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check_val("latency", 64'(cyc), 64'(b.at));
                check_val("m_col", 64'(m_col_o), 64'(b.col));
                check_val("m_row_vld", 64'(m_row_vld_o), 64'(b.rv));
                check_val("m_sof", 64'(m_sof_o), 64'(b.sof));
                check_val("m_eol", 64'(m_eol_o), 64'(b.eol));
            end
        end
    end

    task automatic idle();
        s_vld_i = 1'b0;
        s_dat_i = pixel_t'($urandom);
        s_sof_i = 1'($urandom);
        s_eol_i = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input pixel_t d, input logic sof, input logic eol);
        logic [3:0] e_push;
        logic       e_pop;
        beat_t      b;
        int         r;
        e_push = 4'b0000;
        e_pop  = 1'b0;
        s_vld_i = 1'b1;
        s_dat_i = d;
        s_sof_i = sof;
        s_eol_i = eol;
        if (sof) begin
            m_active = 1;
            m_line   = 0;
            m_col    = 0;
        end
        if (m_active && m_col == IMAGE_MAX_W && !eol) begin
            m_err = 1;
        end else if (m_active) begin
            e_push = 4'b0001 << (m_line % 4);
            e_pop  = (m_line != 0);
            hist[m_line][m_col] = d;
            b.at  = cyc + 3;
            b.col = '0;
            b.rv  = '0;
            b.sof = sof;
            b.eol = eol;
            b.col[5*PIXEL_W-1 -: PIXEL_W] = d;
            for (int j = 1; j <= 4; j++) begin
                r = m_line - 5 + j;
                if (r >= 0) begin
                    b.rv[j-1] = 1'b1;
                    b.col[j*PIXEL_W-1 -: PIXEL_W] = hist[r][m_col];
                end
            end
            exp_q.push_back(b);
            if (eol) begin
                m_line++;
                m_col = 0;
            end else begin
                m_col++;
            end
        end
        #1;
        check_val("lb_push", 64'(lb_push_o), 64'(e_push));
        check_val("lb_pop", 64'(lb_pop_o), 64'(e_pop));
        check_val("lb_eol", 64'(lb_eol_o), 64'(eol ? e_push : 4'b0000));
        check_val("lb_sof", 64'(lb_sof_o), 64'(sof && e_push != 0));
        if (e_push != 0) check_val("lb_dat", 64'(lb_dat_o), 64'(d));
        @(posedge clk);
        #1;
        s_vld_i = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        s_vld_i = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].at > cyc) void'(exp_q.pop_back());
        #1;
        check_val("rdy_in_rst", 64'(s_rdy_o), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_active = 0;
        m_err    = 0;
        check_val("vld_after_rst", 64'(m_vld_o), 64'(0));
        check_val("err_after_rst", 64'(err_o), 64'(0));
    endtask

    task automatic frame(input int w, input int l, input int gap_mode);
        for (int li = 0; li < l; li++) begin
            for (int c = 0; c < w; c++) begin
                send(pixel_t'($urandom), li == 0 && c == 0, c == w - 1);
                if (gap_mode == 1) begin
                    idle();
                    idle();
                end else if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) idle();
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        s_vld_i = 1'b0;
        s_dat_i = '0;
        s_sof_i = 1'b0;
        s_eol_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rdy", 64'(s_rdy_o), 64'(0));
        check_val("rst_m_vld", 64'(m_vld_o), 64'(0));
        check_val("rst_m_col", 64'(m_col_o), 64'(0));
        check_val("rst_row_vld", 64'(m_row_vld_o), 64'(0));
        check_val("rst_err", 64'(err_o), 64'(0));
        check_val("rst_push", 64'(lb_push_o), 64'(0));
        rst = 1'b0;
        idle();

        // Pixels before any sof are ignored.
        for (int i = 0; i < 3; i++) send(pixel_t'(i + 100), 1'b0, i == 2);

        // 4x4 frame with values 1..16.
        for (int i = 1; i <= 16; i++) send(pixel_t'(i), i == 1, i % 4 == 0);
        repeat (4) idle();

        // 6 lines of width 2, wrapping the write pointer.
        frame(2, 6, 0);
        // 1-on / 2-off gaps.
        frame(3, 5, 1);
        // sof mid-line 2 restarts the frame.
        frame(4, 2, 0);
        send(pixel_t'(7), 1'b0, 1'b0);
        send(pixel_t'(8), 1'b0, 1'b0);
        frame(4, 3, 0);

        for (int f = 0; f < 8; f++) begin
            frame($urandom_range(1, IMAGE_MAX_W), $urandom_range(1, 9), 2);
        end

        // Width overflow: two pixels dropped, eol still processed.
        for (int i = 0; i < IMAGE_MAX_W + 3; i++) begin
            send(pixel_t'($urandom), i == 0, i == IMAGE_MAX_W + 2);
        end
        idle();
        check_val("err_set", 64'(err_o), 64'(m_err));
        frame(3, 2, 0);
        check_val("err_held", 64'(err_o), 64'(1));

        // Reset pulsed mid-line, then restart.
        frame(3, 2, 0);
        send(pixel_t'(1), 1'b1, 1'b0);
        send(pixel_t'(2), 1'b0, 1'b0);
        pulse_rst();
        send(pixel_t'(3), 1'b0, 1'b1);
        frame(3, 5, 2);

        repeat (6) idle();
        check_val("drain", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_lbx_seq.md
# conv_lbx_seq

Write-side sequencer and row-ordering stage for the 4-line ASIC line-buffer array in the convolution datapath. It accepts the raw pixel stream and assigns each line round-robin to one of four line buffers. It drives the buffer push/pop/sof/eol controls, then takes the four buffer columns back, rotates them into oldest-to-newest row order, and appends the time-aligned current pixel. Its output is a 5-row column, with per-row validity, for the 5x5 window assembler.

## Interface
- No module parameters; widths come from conv_pkg: `PIXEL_W`, `IMAGE_MAX_W` (line-width limit).
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `s_vld_i` in 1: input pixel valid.
- `s_rdy_o` out 1: input ready; equals `!rst`.
- `s_dat_i` in `pixel_t`: input pixel.
- `s_sof_i` in 1: first pixel of frame.
- `s_eol_i` in 1: last pixel of line.
- `lb_push_o` out [4:1]: one-hot write enable to line buffers.
- `lb_pop_o` out 1: read request to line buffers.
- `lb_dat_o` out `pixel_t`: write data, equal to `s_dat_i`.
- `lb_sof_o` out 1: sof to line buffers.
- `lb_eol_o` out [4:1]: eol, qualified by the write buffer.
- `lb_colD_i` in `pixel_t` [4:1]: buffer read data.
- `m_vld_o` out 1: output column valid.
- `m_col_o` out `pixel_t` [5:1]: index 1 = line n-4 (oldest), index 4 = line n-1, index 5 = current line n.
- `m_row_vld_o` out [4:1]: row j of `m_col_o` holds real data; row 5 is always real.
- `m_sof_o` out 1: marks the first column of a frame.
- `m_eol_o` out 1: marks the last column of a line.
- `err_o` out 1: sticky overflow flag.

## Operation
- Accept: `acc = s_vld_i & s_rdy_o`. There is no downstream back-pressure; the consumer must take every `m_vld_o` beat.
- State machine:
  - IDLE (reset state): accepted pixels without `s_sof_i` are dropped, with no `lb_*` activity. An accepted pixel with `s_sof_i` moves to ACTIVE and is processed.
  - ACTIVE: every accepted pixel is processed. `s_sof_i` in ACTIVE restarts the frame.
- Processed pixel, given write pointer `wr_ptr` (2b) and line count `lines` (3b, saturates at 4):
  - `lb_push_o` = one-hot of bit `wr_ptr+1`.
  - `lb_pop_o` = (`lines` != 0).
  - `lb_eol_o` = `lb_push_o` & {4{`s_eol_i`}}.
  - `lb_sof_o` = `s_sof_i`.
- Pixel counter `pcnt` has width `$clog2(IMAGE_MAX_W)+1`:
  - Increments per processed pixel.
  - Clears on eol or sof.
- Overflow: a pixel arriving with `pcnt == IMAGE_MAX_W` and no eol is dropped (no `lb_*`, no `m_*`) and sets `err_o`. `err_o` clears only on `rst`. An eol pixel in overflow is still processed as eol.
- End of line (eol pixel processed):
  - `wr_ptr` advances +1 mod 4 (3 wraps to 0).
  - `lines` increments, saturating at 4.
- sof pixel: `wr_ptr`, `lines` and `pcnt` are treated as 0 for that pixel, then updated normally. Any partial prior line is abandoned without an eol.
- sof and eol on the same pixel forms a valid 1-pixel line; the pointer then advances to 1.
- Rotation, using `wr_ptr`/`lines` captured at accept: `m_col_o[j]` = `lb_colD_i[((wr_ptr+j-1) mod 4)+1]` for j = 1..4.
- Row validity: `m_row_vld_o[j]` = (`lines` >= 5-j).
- Invalid rows output 0, never stale buffer data.
- `m_col_o[5]` = the accepted pixel, delayed to align with its rotated rows.

## Timing
- Pixel accepted in cycle t:
  - `lb_push_o`/`lb_pop_o`/`lb_eol_o`/`lb_sof_o`/`lb_dat_o` are combinational in cycle t.
  - `lb_colD_i` for that pop is valid in cycle t+2.
  - `m_*` are registered and valid in cycle t+3. Latency is 3 cycles, with throughput of 1 pixel/cycle.
- A 3-stage shift pipe carries: valid, sof, eol, pixel, `wr_ptr`, `lines`.
- Reset values:
  - `m_vld_o`, `m_sof_o`, `m_eol_o`, `err_o` = 0.
  - `m_col_o`, `m_row_vld_o` = 0.
  - `lb_*` = 0.
  - `s_rdy_o` = 0 while `rst` is high.
  - State = IDLE; `wr_ptr`, `lines`, `pcnt` = 0.
- Reset mid-frame: the pipe valids clear the next cycle and in-flight columns are discarded. After `rst` falls, the block sits in IDLE until the next sof.
- `m_vld_o` is never asserted for dropped pixels.

## Test plan
- Reset, then a 4x4 frame of values 1..16 (sof on 1, eol on 4/8/12/16):
  - `lb_push_o` = 0001, 0010, 0100, 1000 per line.
  - `lb_pop_o` = 0 for line 0.
  - First `m_vld_o` 3 cycles after the first accept, with `m_col_o[5]`=1 and `m_row_vld_o`=0000.
  - At pixel 13: `m_col_o[4:1]` = {9,5,1,0} (rows 4..1), `m_row_vld_o`=1110.
- Frame of 6 lines of width 2:
  - Line 4 writes buffer 1 (`wr_ptr` wrap).
  - At line 5 col 0: `m_col_o[1]` = line 1 pixel, `m_row_vld_o`=1111.
- Width overflow: `IMAGE_MAX_W`+3 pixels, with eol on the last:
  - 2 pixels dropped, the eol pixel processed.
  - `err_o`=1 and held until `rst`.
- Pixels before any sof are dropped with no `lb_*`/`m_*` activity. sof mid-line 2 gives `lb_push_o`=0001 and `m_row_vld_o`=0000 on the next column.
- `s_vld_i` gaps (1-on/2-off) produce identical `m_col_o` contents at 3-cycle offsets from each accept.
- `rst` pulsed one cycle mid-line:
  - All `m_vld_o` cease within 1 cycle.
  - The following sof restarts at `wr_ptr`=0.
